sum_sub: RTL and testbench
==========================

Name:
sum_sub

Overview:
- Registered two's-complement adder/subtractor of parametrizable width.
- One control bit selects the operation: f = a + b or f = a − b.
- Also flags signed overflow.
- Used as the arithmetic datapath element in the arithmetic lessons; exercised with random signed operands in add and subtract modes.

Parameters:
WIDTH, 8, operand and result width in bits (must be ≥ 2)

Ports:
clk    input   1      clock; all state updates on rising edge
reset  input   1      synchronous, active-high reset
a      input   WIDTH  first operand, signed two's complement
b      input   WIDTH  second operand, signed two's complement
op     input   1      operation select: 0 = add (a+b), 1 = subtract (a−b)
f      output  WIDTH  result, signed two's complement, registered
ov     output  1      signed overflow flag for the registered result

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset:
  - On a rising clk edge with reset=1: f ← 0, ov ← 0.
  - Reset has priority over any operand or op value.
  - No asynchronous path.
- Datapath: a, b and op are sampled combinationally and the result is registered.
  - Latency is exactly 1 cycle: operands present before edge n appear on f/ov after edge n.
  - A new operation is accepted every cycle.
  - There is no handshake and no state other than the output registers.
- Arithmetic:
  - Implementation is a single adder: s = a + (b XOR {WIDTH{op}}) + op, i.e. op feeds both the b-inversion and the carry-in.
  - The result is truncated to WIDTH bits (modulo 2^WIDTH wrap-around).
  - There is no carry-out port; carry-out is discarded.
- Overflow:
  - ov = carry into MSB XOR carry out of MSB.
  - Equivalently, ov=1 iff both adder operands (a and b XOR op) have the same sign and s has the opposite sign.
  - ov is meaningful for both operations.
  - When ov=1, f still holds the wrapped WIDTH-bit result; it is not saturated.
- Most-negative operand in subtract (b = −2^(WIDTH−1), op=1):
  - Handled by the same adder; no special case.
  - a ≥ 0 gives ov=1; a < 0 gives a correct result with ov=0.
- op may change every cycle; each result uses the op value sampled with its own operands.
- Reset mid-stream:
  - The in-flight result is discarded and outputs read 0/0 after the reset edge.
  - The first valid result appears one edge after reset deasserts.
- X/Z inputs are not required to be handled.

Test Plan:
1. Reset (WIDTH=8): reset=1 for 2 edges with a=55, b=−3, op=0 → f=0, ov=0 after each edge; deassert → next edge f=52, ov=0.
2. Add boundaries (op=0):
   - 100+27 → f=127, ov=0
   - 100+28 → f=−128, ov=1
   - −128+(−1) → f=127, ov=1
   - −64+(−64) → f=−128, ov=0
   - each result appears exactly one edge after its operands.
3. Subtract boundaries (op=1):
   - 5−7 → f=−2, ov=0
   - −128−1 → f=127, ov=1
   - 0−(−128) → f=−128, ov=1
   - −1−(−128) → f=127, ov=0
   - 127−(−1) → f=−128, ov=1
4. Back-to-back op toggle: a=10, b=3 held, op=0,1,0 on consecutive cycles → f=13, 7, 13 on consecutive edges, ov=0.
5. Reset mid-stream: stream of add operations, assert reset for one edge while a=100, b=100 → f=0, ov=0 (not −56/1); resume → results resume with 1-cycle latency.
6. Random regression: 20+ vectors per op with seeds 1 and 2, for WIDTH=8 and WIDTH=16.
   - Compare f against (a±b) mod 2^WIDTH.
   - Compare ov against the sign-rule model, one cycle delayed.

Source files
------------

// File: rtl/sum_sub.sv
// Registered two's-complement adder/subtractor with signed-overflow flag.
// One ripple adder serves both operations: op inverts b and is the carry-in,
// so a - b is computed as a + ~b + 1.

// One bit of the ripple adder.
module sum_sub_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    // Full-adder sum and carry.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
    end
endmodule

module sum_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] f,
    output logic             ov
);
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;

    // b is inverted for subtract and op is the carry-in.
    always_comb begin
        bx   = b ^ {WIDTH{op}};
        c[0] = op;
    end

    // Ripple chain. The carries are kept per bit so the carry into the MSB
    // is available for the overflow test.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sum_sub_fa u_fa (
            .a  (a[i]),
            .b  (bx[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // Register the result. Carry-out is dropped, which gives the modulo
    // wrap. Overflow is the carry into the MSB XOR the carry out of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            f  <= '0;
            ov <= 1'b0;
        end else begin
            f  <= s;
            ov <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
endmodule

// File: tb/tb_sum_sub.sv
// Self-checking bench for sum_sub.
// It uses directed boundary vectors on an 8-bit instance, then random
// vectors on 8-bit and 16-bit instances. Results are checked against an
// integer reference model.
module tb_sum_sub;
    logic        clk;
    logic        reset;
    logic        op;
    logic [7:0]  a8, b8, f8;
    logic [15:0] a16, b16, f16;
    logic        ov8, ov16;

    int          nchk;
    int          nerr;
    logic [7:0]  prev_f8;

    sum_sub #(.WIDTH(8)) u8 (
        .clk   (clk),
        .reset (reset),
        .a     (a8),
        .b     (b8),
        .op    (op),
        .f     (f8),
        .ov    (ov8)
    );

    sum_sub #(.WIDTH(16)) u16 (
        .clk   (clk),
        .reset (reset),
        .a     (a16),
        .b     (b16),
        .op    (op),
        .f     (f16),
        .ov    (ov16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference model: exact integer result, then a range check and a mask.
    function automatic void model(input int w, input int x, input int y, input bit o,
                                  output logic [31:0] fe, output logic oe);
        longint r;
        longint lim;
        r   = o ? (longint'(x) - longint'(y)) : (longint'(x) + longint'(y));
        lim = longint'(1) << (w - 1);
        oe  = (r >= lim) || (r < -lim);
        fe  = 32'(r) & ((32'd1 << w) - 32'd1);
    endfunction

    // Directed 8-bit vector. f must hold its old value until the edge, then
    // show the expected result.
    task automatic dir(input string tag, input int x, input int y, input bit o,
                       input int fexp, input bit ovexp);
        a8 = 8'(x);
        b8 = 8'(y);
        op = o;
        #1;
        chk({tag, "_hold"}, {24'd0, f8}, {24'd0, prev_f8});
        @(posedge clk);
        #1;
        chk({tag, "_f"}, {24'd0, f8}, {24'd0, 8'(fexp)});
        chk({tag, "_ov"}, {31'd0, ov8}, {31'd0, ovexp});
        prev_f8 = 8'(fexp);
    endtask

    initial begin
        logic [31:0] fe;
        logic        oe;
        nchk    = 0;
        nerr    = 0;
        prev_f8 = '0;
        reset   = 1'b1;
        op      = 1'b0;
        a8      = 8'd55;
        b8      = 8'(-3);
        a16     = 16'd55;
        b16     = 16'(-3);

        // Reset held for two edges with live operands.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_f8", {24'd0, f8}, 32'd0);
            chk("rst_ov8", {31'd0, ov8}, 32'd0);
            chk("rst_f16", {16'd0, f16}, 32'd0);
            chk("rst_ov16", {31'd0, ov16}, 32'd0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_f8", {24'd0, f8}, 32'd52);
        chk("post_rst_ov8", {31'd0, ov8}, 32'd0);
        prev_f8 = 8'd52;

        // Add boundaries.
        dir("add0", 100, 27, 0, 127, 0);
        dir("add1", 100, 28, 0, -128, 1);
        dir("add2", -128, -1, 0, 127, 1);
        dir("add3", -64, -64, 0, -128, 0);

        // Subtract boundaries.
        dir("sub0", 5, 7, 1, -2, 0);
        dir("sub1", -128, 1, 1, 127, 1);
        dir("sub2", 0, -128, 1, -128, 1);
        dir("sub3", -1, -128, 1, 127, 0);
        dir("sub4", 127, -1, 1, -128, 1);

        // op toggled every cycle with the same operands.
        dir("tog0", 10, 3, 0, 13, 0);
        dir("tog1", 10, 3, 1, 7, 0);
        dir("tog2", 10, 3, 0, 13, 0);

        // Reset in the middle of a stream.
        dir("ms0", 1, 2, 0, 3, 0);
        dir("ms1", 20, 30, 0, 50, 0);
        reset = 1'b1;
        a8    = 8'd100;
        b8    = 8'd100;
        op    = 1'b0;
        @(posedge clk);
        #1;
        chk("ms_rst_f", {24'd0, f8}, 32'd0);
        chk("ms_rst_ov", {31'd0, ov8}, 32'd0);
        prev_f8 = '0;
        reset   = 1'b0;
        dir("ms2", 100, 100, 0, -56, 1);
        dir("ms3", 7, 9, 1, -2, 0);

        // Random regression on both widths. Some vectors force the
        // most-negative b.
        for (int s = 1; s <= 2; s++) begin
            void'($urandom(s));
            for (int i = 0; i < 48; i++) begin
                op  = i[0];
                a8  = 8'($urandom);
                b8  = 8'($urandom);
                a16 = 16'($urandom);
                b16 = 16'($urandom);
                if ($urandom_range(0, 7) == 0) begin
                    b8  = 8'h80;
                    b16 = 16'h8000;
                end
                @(posedge clk);
                #1;
                model(8, int'($signed(a8)), int'($signed(b8)), op, fe, oe);
                chk("rnd8_f", {24'd0, f8}, fe);
                chk("rnd8_ov", {31'd0, ov8}, {31'd0, oe});
                model(16, int'($signed(a16)), int'($signed(b16)), op, fe, oe);
                chk("rnd16_f", {16'd0, f16}, fe);
                chk("rnd16_ov", {31'd0, ov16}, {31'd0, oe});
            end
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule
